jk_seq_ctrl: RTL and testbench
==============================

Name: jk_seq_ctrl

Overview:
Sequencing controller for an external bank of WIDTH JK flip-flops that share its clock.
- Each cycle it computes per-bit J/K excitation from the bank's fed-back state, so the bank steps through up-count, down-count, ring or Johnson sequences.
- Also loads an arbitrary value and runs for a programmed number of steps, with a start/busy/done handshake.
- Sits between a host/sequencer and the flip-flop bank; the bank's own preset/clear are not driven by this block.

Parameters:
WIDTH, 4, number of JK flip-flops in the controlled bank (>=2)
LEN_W, 8, width of the step-length field

Ports:
clk  input  1  rising-edge clock, shared with the flip-flop bank
clr  input  1  asynchronous active-low reset
start  input  1  begin a run (sampled in IDLE only)
mode  input  2  00 up, 01 down, 10 ring rotate-left, 11 Johnson; latched at start
len  input  LEN_W  number of steps for the run; latched at start
step_en  input  1  in RUN: 1 = advance this cycle, 0 = hold
abort  input  1  in RUN: terminate the run without done
load  input  1  in IDLE: load load_val into the bank
load_val  input  WIDTH  value to load
q_fb  input  WIDTH  current Q of the bank
J  output  WIDTH  J inputs of the bank
K  output  WIDTH  K inputs of the bank
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when a run completes
wrap  output  1  counter wrap pulse (see Optional Feature)

Behaviour:
- One clock `clk`; reset `clr` is asynchronous, active-low. While clr=0:
  - state=IDLE, step counter=0, latched mode=00.
  - busy=0, done=0, wrap=0, J=K=0.
- Excitation rule, for a target next value n and current q=q_fb, applied per bit:
  - J = n & ~q
  - K = q & ~n
  - Unchanged bits therefore get J=K=0 (hold). The 11 toggle code is never emitted.
- Next value n by latched mode, all arithmetic modulo 2^WIDTH:
  - up: q+1
  - down: q-1
  - ring: {q[WIDTH-2:0], q[WIDTH-1]}
  - Johnson: {q[WIDTH-2:0], ~q[WIDTH-1]}
- J/K are combinational from state, latched mode and q_fb. All other outputs are registered.
- States: IDLE, RUN, DONE.
- IDLE:
  - J=K=0, except when load=1: n=load_val, so the bank holds load_val after that edge.
  - start=1 and load=0: latch mode and len, go to RUN (or to DONE if len=0).
  - start and load in the same cycle: load wins, start is ignored.
- RUN:
  - busy=1.
  - abort=1: J=K=0, go to IDLE, no done. abort has priority over step_en.
  - step_en=1: drive the excitation and decrement the counter; if the counter was 1, go to DONE.
  - step_en=0: J=K=0, counter held, stay in RUN.
  - start and load are ignored.
- DONE: J=K=0, done=1 for exactly one cycle, then IDLE. A start in DONE is ignored.
- Latency: start sampled at edge t gives RUN from t+1. With step_en held high and len=L, done is high in cycle t+L+1 and the bank holds the L-th successor value.
- clr asserted mid-run: immediate return to reset values. The bank keeps its Q.

Optional Feature:
- Macro: JK_SEQ_WRAP_FLAG_EN.
- Defined: wrap pulses high for one cycle, registered, after a RUN step in which:
  - up mode had q_fb all-ones, or
  - down mode had q_fb all-zeros.
- Ring and Johnson modes never assert wrap.
- Undefined: the wrap port exists but is tied to 0, and no wrap logic is generated.

Decomposition:
- Shared package jk_seq_pkg holds:
  - mode encodings (MODE_UP, MODE_DOWN, MODE_RING, MODE_JOHNSON)
  - state typedef (IDLE, RUN, DONE)
- One natural sub-module, jk_excite: purely combinational (q, n) -> (J, K), parameterised by WIDTH.
- Next-value selection and FSM stay in jk_seq_ctrl.

Test Plan:
1. Load, WIDTH=4: IDLE, q_fb=0000, load=1, load_val=1010 -> J=1010, K=0000 that cycle; busy=0, done=0.
2. Up count: q_fb=0111, start, mode=00, len=3, step_en=1 -> first step J=1000, K=0111; bank goes 1000, 1001, 1010; done one-cycle pulse in cycle start+4; busy high 3 cycles.
3. Johnson: q_fb=0000, mode=11, len=8 -> bank visits 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; done after 8th step.
4. Stall and abort:
   - len=3 with step_en low for 2 cycles mid-run -> J=K=0 in those cycles; done at start+6.
   - Separate run with abort in 2nd RUN cycle -> IDLE next cycle, done never asserted.
5. Edge cases:
   - start with len=0 -> DONE next cycle, done pulse, no nonzero J/K.
   - start+load together -> load only, stays IDLE.
   - clr low mid-run -> J=K=0, busy=0 immediately.
6. With JK_SEQ_WRAP_FLAG_EN:
   - down from 0000, len=1 -> bank 1111, wrap=1 one cycle.
   - Without the macro, wrap stays 0 throughout.

Source files
------------

// File: rtl/jk_seq_pkg.sv
// jk_seq_pkg: shared mode encodings and FSM state constants for jk_seq_ctrl
package jk_seq_pkg;
  localparam logic [1:0] MODE_UP      = 2'b00;
  localparam logic [1:0] MODE_DOWN    = 2'b01;
  localparam logic [1:0] MODE_RING    = 2'b10;
  localparam logic [1:0] MODE_JOHNSON = 2'b11;
  // RUN and DONE each own one bit so busy/done come straight off a flop.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'b00;
  localparam state_t RUN  = 2'b01;
  localparam state_t DONE = 2'b10;
endpackage

// File: rtl/jk_excite.sv
// jk_excite: per-bit JK excitation that moves a bank from q to n
//   q_i : current bank state
//   n_i : desired next state
//   j_o : J inputs (set where 0 -> 1)
//   k_o : K inputs (clear where 1 -> 0); the 11 toggle code never appears
module jk_excite #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] n_i,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o
);
  assign j_o = n_i & ~q_i;
  assign k_o = q_i & ~n_i;
endmodule

// File: rtl/jk_seq_ctrl.sv
// jk_seq_ctrl: sequencing controller driving J/K of an external JK flip-flop bank
//   clk      : rising-edge clock shared with the bank
//   clr      : asynchronous active-low reset
//   start    : begin a run (IDLE only); mode/len latched here
//   mode     : 00 up, 01 down, 10 ring rotate-left, 11 Johnson
//   len      : number of steps in the run
//   step_en  : RUN advance enable, abort terminates RUN without done
//   load     : IDLE load of load_val into the bank (beats start)
//   q_fb     : bank Q feedback
//   J, K     : bank excitation (combinational)
//   busy     : high in RUN; done: one-cycle completion pulse
//   wrap     : registered up/down wrap pulse, only when JK_SEQ_WRAP_FLAG_EN is defined
module jk_seq_ctrl
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] len,
  input  logic             step_en,
  input  logic             abort,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             busy,
  output logic             done,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] Q_ONE = WIDTH'(1);
  localparam logic [LEN_W-1:0] L_ONE = LEN_W'(1);
  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             step, ld_en;
  logic [WIDTH-1:0] succ, n;
  always_comb begin
    succ = (mode_q == MODE_UP)   ? q_fb + Q_ONE :
           (mode_q == MODE_DOWN) ? q_fb - Q_ONE :
           (mode_q == MODE_RING) ? {q_fb[WIDTH-2:0], q_fb[WIDTH-1]} :
                                   {q_fb[WIDTH-2:0], ~q_fb[WIDTH-1]};
  end
  // clr gates the enables so J/K are held at zero throughout reset.
  assign step  = clr && state_q == RUN && !abort && step_en;
  assign ld_en = clr && state_q == IDLE && load;
  // Targeting the current value yields J=K=0, i.e. the bank holds.
  assign n = ld_en ? load_val : step ? succ : q_fb;
  jk_excite #(.WIDTH(WIDTH)) u_excite (
    .q_i(q_fb),
    .n_i(n),
    .j_o(J),
    .k_o(K)
  );
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (start && !load) begin
        mode_d  = mode;
        cnt_d   = len;
        state_d = (len == '0) ? DONE : RUN;
      end
    end else if (state_q == RUN) begin
      if (abort) begin
        cnt_d   = '0;
        state_d = IDLE;
      end else if (step_en) begin
        cnt_d   = cnt_q - L_ONE;
        state_d = (cnt_q == L_ONE) ? DONE : RUN;
      end
    end else begin
      // DONE, or the unused encoding, always falls back to IDLE.
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      mode_q  <= MODE_UP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end
  assign busy = state_q[0];
  assign done = state_q[1];
`ifdef JK_SEQ_WRAP_FLAG_EN
  logic wrap_q;
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) wrap_q <= 1'b0;
    else wrap_q <= step && ((mode_q == MODE_UP && &q_fb) || (mode_q == MODE_DOWN && ~|q_fb));
  end
  assign wrap = wrap_q;
`else
  assign wrap = 1'b0;
`endif
endmodule

// File: tb/tb_jk_seq_ctrl.sv
// tb_jk_seq_ctrl: randomized and directed self-checking bench for jk_seq_ctrl with a JK bank model
module tb_jk_seq_ctrl;
  localparam int W  = 4;
  localparam int LW = 8;
  localparam int M  = 1 << W;
  logic          clk = 1'b0;
  logic          clr;
  logic          start;
  logic [1:0]    mode;
  logic [LW-1:0] len;
  logic          step_en, abort, load;
  logic [W-1:0]  load_val, q_fb, J, K;
  logic          busy, done, wrap;
  int            checks = 0;
  int            errors = 0;
  bit            m_run, m_done, m_wrap;
  int            m_left, m_mode;

  jk_seq_ctrl #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk(clk), .clr(clr), .start(start), .mode(mode), .len(len),
    .step_en(step_en), .abort(abort), .load(load), .load_val(load_val),
    .q_fb(q_fb), .J(J), .K(K), .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int succ(input int q, input int md);
    case (md)
      0:       return (q + 1) % M;
      1:       return (q + M - 1) % M;
      2:       return (q * 2) % M + q / (M / 2);
      default: return (q * 2) % M + 1 - q / (M / 2);
    endcase
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, clock the bank.
  task automatic cyc(input bit st, input int md, input int ln, input bit se,
                     input bit ab, input bit ld, input int lv);
    int q, n;
    logic [W-1:0] bank_next;
    start = st; mode = md[1:0]; len = ln[LW-1:0];
    step_en = se; abort = ab; load = ld; load_val = lv[W-1:0];
    #1;
    q = int'(q_fb);
    n = q;
    if (!m_run && !m_done && ld) n = lv % M;
    else if (m_run && !ab && se) n = succ(q, m_mode);
    check("J", J, n & ~q & (M - 1));
    check("K", K, q & ~n & (M - 1));
    check("busy", busy, m_run);
    check("done", done, m_done);
    check("wrap", wrap, m_wrap);
    bank_next = (J & ~q_fb) | (~K & q_fb);
    m_wrap = 0;
    if (m_done) m_done = 0;
    else if (m_run) begin
      if (ab) m_run = 0;
      else if (se) begin
`ifdef JK_SEQ_WRAP_FLAG_EN
        m_wrap = (m_mode == 0 && q == M - 1) || (m_mode == 1 && q == 0);
`endif
        m_left--;
        if (m_left == 0) begin
          m_run  = 0;
          m_done = 1;
        end
      end
    end else if (st && !ld) begin
      m_mode = md;
      if (ln % (1 << LW) == 0) m_done = 1;
      else begin
        m_run  = 1;
        m_left = ln % (1 << LW);
      end
    end
    @(posedge clk);
    #1;
    q_fb = bank_next;
  endtask

  task automatic do_reset();
    clr = 1'b0; load = 1'b1; load_val = ~q_fb; start = 1'b1; step_en = 1'b1; abort = 1'b0;
    #1;
    check("rst_J", J, 0);
    check("rst_K", K, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wrap", wrap, 0);
    @(posedge clk);
    #1;
    check("rst_hold_busy", busy, 0);
    m_run = 0; m_done = 0; m_wrap = 0; m_left = 0; m_mode = 0;
    clr = 1'b1;
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; mode = '0; len = '0; step_en = 1'b0;
    abort = 1'b0; load = 1'b0; load_val = '0; q_fb = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    q_fb = 4'h0; cyc(0, 0, 0, 0, 0, 1, 'ha);
    check("load_bank", q_fb, 'ha);
    q_fb = 4'h7; cyc(1, 0, 3, 1, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 1, 0, 0, 0);
    check("up_bank", q_fb, 'ha);
    q_fb = 4'h0; cyc(1, 3, 8, 1, 0, 0, 0);
    repeat (9) cyc(0, 0, 0, 1, 0, 0, 0);
    check("johnson_bank", q_fb, 'h0);
    q_fb = 4'h3; cyc(1, 0, 3, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("stall_bank", q_fb, 'h6);
    q_fb = 4'h1; cyc(1, 2, 4, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("abort_bank", q_fb, 'h2);
    q_fb = 4'h5; cyc(1, 1, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("len0_bank", q_fb, 'h5);
    q_fb = 4'h2; cyc(1, 0, 5, 1, 0, 1, 'h5);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("startload_bank", q_fb, 'h5);
    q_fb = 4'h0; cyc(1, 1, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("down_wrap_bank", q_fb, 'hf);
    q_fb = 4'hf; cyc(1, 0, 2, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("up_wrap_bank", q_fb, 'h1);
    q_fb = 4'h0; cyc(1, 0, 5, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    do_reset();
    check("clr_bank_kept", q_fb, 'h2);
    repeat (800) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      else cyc($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
               $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
               int'($urandom_range(0, M - 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
